// File: rtl/x_stack_mpu.sv
// x_stack_mpu: MSP430 bus access monitor with NREG protected data regions,
// trusted-ROM entry/exit checks, held kill, sticky cause and saturating count.
// Optional DMA address checking is enabled with `define XSTACK_DMA_CHECK_EN.
module x_stack_mpu #(
  parameter int                   AW            = 16,
  parameter int                   NREG          = 4,
  parameter int                   RIDX_W        = 2,
  parameter logic [AW*NREG-1:0]   REGION_BASE   = {16'h9000, 16'hFEFE, 16'h8000, 16'h0400},
  parameter logic [AW*NREG-1:0]   REGION_SIZE   = {16'h001F, 16'h001F, 16'h001F, 16'h0C00},
  parameter logic [2*NREG-1:0]    REGION_PERM   = 8'b01_00_01_00,
  parameter logic [AW-1:0]        TRUST_BASE    = 16'hA000,
  parameter logic [AW-1:0]        TRUST_SIZE    = 16'h4000,
  parameter logic [AW-1:0]        RESET_HANDLER = 16'hFFFE,
  parameter int                   MIN_KILL      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AW-1:0]     pc,
  input  logic              pc_en,
  input  logic [AW-1:0]     data_addr,
  input  logic              r_en,
  input  logic              w_en,
  input  logic              cause_clr,
`ifdef XSTACK_DMA_CHECK_EN
  input  logic [AW-1:0]     dma_addr,
  input  logic              dma_en,
`endif
  output logic              kill,
  output logic              viol_valid,
  output logic [2:0]        viol_cause,
  output logic [RIDX_W-1:0] viol_region,
  output logic [7:0]        viol_count
);

  localparam int HCW = (MIN_KILL > 1) ? $clog2(MIN_KILL) : 1;
  // Last legal trusted PC, also the only legal exit point.
  localparam logic [AW:0] TRUST_LAST = {1'b0, TRUST_BASE} + {1'b0, TRUST_SIZE} - (AW+1)'(2);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_KILL = 1'b1
  } state_t;

  typedef enum logic [2:0] {
    C_NONE  = 3'd0,
    C_ENTRY = 3'd1,
    C_EXIT  = 3'd2,
    C_WRITE = 3'd3,
    C_READ  = 3'd4,
    C_DMA   = 3'd5
  } cause_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [HCW-1:0]      r_hold_cnt;
  logic [HCW-1:0]      w_hold_nxt;
  logic                w_enter_kill;
  logic [AW-1:0]       r_prev_pc;
  logic                r_viol_valid;
  logic [2:0]          r_cause;
  logic [RIDX_W-1:0]   r_region;
  logic [7:0]          r_count;

  logic                w_pc_trusted;
  logic                w_prev_trusted;
  logic                w_entry;
  logic                w_exit;
  logic [NREG-1:0]     w_rd_v;
  logic [NREG-1:0]     w_wr_v;
  logic [NREG-1:0]     w_dma_v;
  cause_t              w_cause;
  logic [RIDX_W-1:0]   w_region;
  logic                w_viol;

  // Upper bound is exclusive in AW+1 bits, so a zero size never matches.
  function automatic logic f_hit(input logic [AW-1:0] addr, input int unsigned idx);
    logic [AW:0] lo;
    logic [AW:0] hi;
    lo = {1'b0, REGION_BASE[idx*AW +: AW]};
    hi = lo + {1'b0, REGION_SIZE[idx*AW +: AW]};
    return ({1'b0, addr} >= lo) && ({1'b0, addr} < hi);
  endfunction

  function automatic logic f_trusted(input logic [AW-1:0] addr);
    return ({1'b0, addr} >= {1'b0, TRUST_BASE}) && ({1'b0, addr} <= TRUST_LAST);
  endfunction

  function automatic logic [RIDX_W-1:0] f_lowest(input logic [NREG-1:0] v);
    logic [RIDX_W-1:0] idx;
    logic              found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (v[i] && !found) begin
        idx   = RIDX_W'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  assign w_pc_trusted   = f_trusted(pc);
  assign w_prev_trusted = f_trusted(r_prev_pc);
  assign w_entry = pc_en && !w_prev_trusted && w_pc_trusted && (pc != TRUST_BASE);
  assign w_exit  = pc_en && w_prev_trusted && !w_pc_trusted && (r_prev_pc != TRUST_LAST[AW-1:0]);

  always_comb begin
    w_rd_v  = '0;
    w_wr_v  = '0;
    w_dma_v = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      w_rd_v[i] = !w_pc_trusted && r_en && f_hit(data_addr, i) && !REGION_PERM[2*i];
      w_wr_v[i] = !w_pc_trusted && w_en && f_hit(data_addr, i) && !REGION_PERM[2*i+1];
`ifdef XSTACK_DMA_CHECK_EN
      w_dma_v[i] = dma_en && f_hit(dma_addr, i);
`endif
    end
  end

  always_comb begin
    w_cause  = C_NONE;
    w_region = '0;
    if (w_entry) begin
      w_cause = C_ENTRY;
    end else if (w_exit) begin
      w_cause = C_EXIT;
    end else if (|w_wr_v) begin
      w_cause  = C_WRITE;
      w_region = f_lowest(w_wr_v);
    end else if (|w_rd_v) begin
      w_cause  = C_READ;
      w_region = f_lowest(w_rd_v);
    end else if (|w_dma_v) begin
      w_cause  = C_DMA;
      w_region = f_lowest(w_dma_v);
    end
  end

  assign w_viol = (w_cause != C_NONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_RUN;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_nxt;
    end
  end

  // Violations seen while already in KILL neither restart the hold nor count.
  always_comb begin
    w_state_nxt  = r_state;
    w_hold_nxt   = r_hold_cnt;
    w_enter_kill = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_viol) begin
          w_state_nxt  = ST_KILL;
          w_hold_nxt   = HCW'(MIN_KILL - 1);
          w_enter_kill = 1'b1;
        end
      end
      ST_KILL: begin
        if ((r_hold_cnt == '0) && (pc == RESET_HANDLER) && !w_viol) begin
          w_state_nxt = ST_RUN;
        end else if (r_hold_cnt != '0) begin
          w_hold_nxt = r_hold_cnt - HCW'(1);
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev_pc    <= RESET_HANDLER;
      r_viol_valid <= 1'b0;
      r_cause      <= '0;
      r_region     <= '0;
      r_count      <= '0;
    end else begin
      if (pc_en) begin
        r_prev_pc <= pc;
      end
      r_viol_valid <= w_enter_kill;
      // A first capture takes precedence over a simultaneous clear.
      if (w_enter_kill && (r_cause == '0)) begin
        r_cause  <= w_cause;
        r_region <= w_region;
      end else if (cause_clr) begin
        r_cause  <= '0;
        r_region <= '0;
      end
      if (w_enter_kill && (r_count != 8'hFF)) begin
        r_count <= r_count + 8'd1;
      end
    end
  end

  assign kill        = (r_state == ST_KILL);
  assign viol_valid  = r_viol_valid;
  assign viol_cause  = r_cause;
  assign viol_region = r_region;
  assign viol_count  = r_count;

endmodule

// File: tb/tb_x_stack_mpu.sv
// Self-checking bench for x_stack_mpu: directed scenarios plus random traffic
// compared every cycle against an integer reference model.
module tb_x_stack_mpu;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pc;
  logic        pc_en;
  logic [15:0] data_addr;
  logic        r_en;
  logic        w_en;
  logic        cause_clr;
`ifdef XSTACK_DMA_CHECK_EN
  logic [15:0] dma_addr;
  logic        dma_en;
`endif
  logic        kill;
  logic        viol_valid;
  logic [2:0]  viol_cause;
  logic [1:0]  viol_region;
  logic [7:0]  viol_count;

  always #5 clk = ~clk;

  x_stack_mpu dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .pc_en       (pc_en),
    .data_addr   (data_addr),
    .r_en        (r_en),
    .w_en        (w_en),
    .cause_clr   (cause_clr),
`ifdef XSTACK_DMA_CHECK_EN
    .dma_addr    (dma_addr),
    .dma_en      (dma_en),
`endif
    .kill        (kill),
    .viol_valid  (viol_valid),
    .viol_cause  (viol_cause),
    .viol_region (viol_region),
    .viol_count  (viol_count)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Region table decoded from the default parameters.
  int rb    [4] = '{'h0400, 'h8000, 'hFEFE, 'h9000};
  int rs    [4] = '{'h0C00, 'h001F, 'h001F, 'h001F};
  int rd_ok [4] = '{0, 1, 0, 1};
  int wr_ok [4] = '{0, 0, 0, 0};

  bit m_killed;
  int m_hold;
  int m_prev;
  int m_cause;
  int m_region;
  int m_count;
  bit m_vv;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit in_rom(input int a);
    return (a >= 'hA000) && (a <= 'hDFFE);
  endfunction

  function automatic void ref_cause(input int p, input bit pe, input int a, input bit re,
                                    input bit we, input bit de, input int da,
                                    output int c, output int r);
    int wr_i, rd_i, dm_i;
    bit t;
    wr_i = -1; rd_i = -1; dm_i = -1;
    t = in_rom(p);
    for (int i = 0; i < 4; i++) begin
      if (!t && we && !wr_ok[i] && a >= rb[i] && a < rb[i] + rs[i] && wr_i < 0) wr_i = i;
      if (!t && re && !rd_ok[i] && a >= rb[i] && a < rb[i] + rs[i] && rd_i < 0) rd_i = i;
      if (de && da >= rb[i] && da < rb[i] + rs[i] && dm_i < 0) dm_i = i;
    end
    c = 0; r = 0;
    if (pe && !in_rom(m_prev) && t && p != 'hA000) c = 1;
    else if (pe && in_rom(m_prev) && !t && m_prev != 'hDFFE) c = 2;
    else if (wr_i >= 0) begin c = 3; r = wr_i; end
    else if (rd_i >= 0) begin c = 4; r = rd_i; end
    else if (dm_i >= 0) begin c = 5; r = dm_i; end
  endfunction

  task automatic cyc(input bit rst, input int p, input bit pe, input int a,
                     input bit re, input bit we, input bit clr);
    int c, r;
    bit de;
    int da;
    bit enter;
    reset = rst; pc = p[15:0]; pc_en = pe; data_addr = a[15:0];
    r_en = re; w_en = we; cause_clr = clr;
    de = 1'b0; da = 0;
`ifdef XSTACK_DMA_CHECK_EN
    de = dma_en; da = int'(dma_addr);
`endif
    ref_cause(p, pe, a, re, we, de, da, c, r);
    @(posedge clk);
    if (rst) begin
      m_killed = 0; m_hold = 0; m_prev = 'hFFFE;
      m_cause = 0; m_region = 0; m_count = 0; m_vv = 0;
    end else begin
      enter = !m_killed && (c != 0);
      m_vv = enter;
      if (enter) begin
        m_killed = 1; m_hold = 3;
        if (m_count < 255) m_count++;
      end else if (m_killed) begin
        if (m_hold == 0 && p == 'hFFFE && c == 0) m_killed = 0;
        else if (m_hold > 0) m_hold--;
      end
      if (enter && m_cause == 0) begin m_cause = c; m_region = r; end
      else if (clr) begin m_cause = 0; m_region = 0; end
      if (pe) m_prev = p;
    end
    #1;
    check_eq("kill",        kill,        m_killed);
    check_eq("viol_valid",  viol_valid,  m_vv);
    check_eq("viol_cause",  viol_cause,  m_cause);
    check_eq("viol_region", viol_region, m_region);
    check_eq("viol_count",  viol_count,  m_count);
  endtask

  task automatic do_reset();
    cyc(1, 'hFFFE, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int p, a;
`ifdef XSTACK_DMA_CHECK_EN
    dma_en = 1'b0; dma_addr = '0;
`endif
    m_prev = 'hFFFE;
    do_reset();
    check_eq("rst_kill", kill, 0);
    check_eq("rst_count", viol_count, 0);

    // Untrusted write into region 0.
    cyc(0, 'hE000, 0, 'h0500, 0, 1, 0);
    check_eq("wr0_kill", kill, 1);
    check_eq("wr0_vv", viol_valid, 1);
    check_eq("wr0_cause", viol_cause, 3);
    check_eq("wr0_region", viol_region, 0);
    check_eq("wr0_count", viol_count, 1);

    // Reset while in KILL.
    cyc(1, 'hE000, 0, 0, 0, 0, 0);
    check_eq("rstk_kill", kill, 0);
    check_eq("rstk_count", viol_count, 0);
    check_eq("rstk_cause", viol_cause, 0);

    // Region 1 read allowed, write denied.
    cyc(0, 'hE000, 0, 'h8004, 1, 0, 0);
    check_eq("rd1_kill", kill, 0);
    cyc(0, 'hE000, 0, 'h8004, 0, 1, 0);
    check_eq("wr1_kill", kill, 1);
    check_eq("wr1_cause", viol_cause, 3);
    check_eq("wr1_region", viol_region, 1);

    // Trusted code may write anywhere.
    do_reset();
    cyc(0, 'hA000, 1, 'h0500, 0, 1, 0);
    check_eq("trw_kill", kill, 0);

    // Illegal and legal entry.
    do_reset();
    cyc(0, 'hE000, 1, 0, 0, 0, 0);
    cyc(0, 'hA010, 1, 0, 0, 0, 0);
    check_eq("entry_cause", viol_cause, 1);
    do_reset();
    cyc(0, 'hE000, 1, 0, 0, 0, 0);
    cyc(0, 'hA000, 1, 0, 0, 0, 0);
    check_eq("entry_ok_kill", kill, 0);

    // Illegal and legal exit.
    do_reset();
    cyc(0, 'hA000, 1, 0, 0, 0, 0);
    cyc(0, 'hA100, 1, 0, 0, 0, 0);
    cyc(0, 'h5000, 1, 0, 0, 0, 0);
    check_eq("exit_cause", viol_cause, 2);
    do_reset();
    cyc(0, 'hA000, 1, 0, 0, 0, 0);
    cyc(0, 'hDFFE, 1, 0, 0, 0, 0);
    cyc(0, 'h5000, 1, 0, 0, 0, 0);
    check_eq("exit_ok_kill", kill, 0);

    // Minimum hold: release PC presented from the 2nd KILL cycle.
    do_reset();
    cyc(0, 'hE000, 0, 'h0500, 0, 1, 0);
    cyc(0, 'h0000, 0, 0, 0, 0, 0);
    check_eq("hold_c2", kill, 1);
    cyc(0, 'hFFFE, 0, 0, 0, 0, 0);
    check_eq("hold_c3", kill, 1);
    cyc(0, 'hFFFE, 0, 0, 0, 0, 0);
    check_eq("hold_c4", kill, 1);
    cyc(0, 'hFFFE, 0, 0, 0, 0, 0);
    check_eq("hold_rel", kill, 0);
    check_eq("sticky_cause", viol_cause, 3);
    // Second event with a different cause leaves the sticky value alone.
    cyc(0, 'hE000, 0, 'hFF00, 1, 0, 0);
    check_eq("sticky2_cause", viol_cause, 3);
    check_eq("sticky2_region", viol_region, 0);
    check_eq("sticky2_count", viol_count, 2);
    cyc(0, 'hE000, 0, 0, 0, 0, 1);
    check_eq("clr_cause", viol_cause, 0);

    // Capture beats clear in the same cycle.
    do_reset();
    cyc(0, 'hE000, 0, 'h0500, 0, 1, 1);
    check_eq("capclr_cause", viol_cause, 3);

    // Counter saturation.
    do_reset();
    for (int n = 0; n < 300; n++) begin
      cyc(0, 'hE000, 0, 'h0500, 0, 1, 0);
      for (int k = 0; k < 4; k++) cyc(0, 'hFFFE, 0, 0, 0, 0, 0);
    end
    check_eq("sat_count", viol_count, 255);

`ifdef XSTACK_DMA_CHECK_EN
    do_reset();
    dma_en = 1'b1; dma_addr = 16'hFF00;
    cyc(0, 'hA000, 0, 0, 0, 0, 0);
    dma_en = 1'b0;
    check_eq("dma_cause", viol_cause, 5);
    check_eq("dma_region", viol_region, 2);
`endif

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 5))
        0: p = 'hFFFE;
        1: p = 'hA000;
        2: p = 'hDFFE;
        3: p = 'hA000 + 2 * $urandom_range(0, 'h1FFF);
        4: p = $urandom_range(0, 'h9FFF);
        default: p = 'hE000 + 2 * $urandom_range(0, 'h0FFF);
      endcase
      if ($urandom_range(0, 1) == 0) begin
        a = rb[$urandom_range(0, 3)] + $urandom_range(0, 'h24) - 2;
      end else begin
        a = $urandom_range(0, 'hFFFF);
      end
`ifdef XSTACK_DMA_CHECK_EN
      dma_en   = ($urandom_range(0, 9) == 0);
      dma_addr = 16'(rb[$urandom_range(0, 3)] + $urandom_range(0, 'h30) - 4);
`endif
      cyc(($urandom_range(0, 199) == 0), p, $urandom_range(0, 1), a,
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 15) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/x_stack_mpu.md
Name: x_stack_mpu

Overview:
- Parametrised hardware access monitor for the MSP430 core bus, watching PC and data-bus strobes every cycle.
- Generalises the single-region kill monitor to NREG data regions, each with per-region read/write permission for code running outside the trusted ROM.
- Adds trusted-ROM entry/exit atomicity checks, a minimum kill hold time, a sticky violation-cause register and a saturating violation counter.
- `kill` drives the core/key reset path.

Parameters:
- AW, 16: address width of pc and data_addr.
- NREG, 4: number of protected data regions (1..16).
- RIDX_W, 2: width of the region index output; must satisfy 2^RIDX_W >= NREG.
- REGION_BASE, {16'h9000,16'hFEFE,16'h8000,16'h0400}: packed AW*NREG; region i occupies bits [i*AW +: AW].
- REGION_SIZE, {16'h001F,16'h001F,16'h001F,16'h0C00}: packed AW*NREG; size in bytes.
- REGION_PERM, 8'b01_00_01_00: packed 2*NREG; bit 2i = read allowed, bit 2i+1 = write allowed, both for untrusted PC.
- TRUST_BASE, 16'hA000: trusted ROM base; the only legal entry address.
- TRUST_SIZE, 16'h4000: trusted ROM size; the legal exit address is TRUST_BASE+TRUST_SIZE-2.
- RESET_HANDLER, 16'hFFFE: PC value that permits release from KILL.
- MIN_KILL, 4: minimum number of cycles `kill` stays high (>=1).

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- pc, input, AW: current program counter.
- pc_en, input, 1: pc is valid this cycle (instruction fetch).
- data_addr, input, AW: data bus address.
- r_en, input, 1: data read strobe.
- w_en, input, 1: data write strobe.
- cause_clr, input, 1: clears the sticky cause register.
- kill, output, 1: registered kill/reset request.
- viol_valid, output, 1: one-cycle pulse on each RUN->KILL transition.
- viol_cause, output, 3: sticky cause. 0=none, 1=entry, 2=exit, 3=write, 4=read.
- viol_region, output, RIDX_W: region index for causes 3 and 4; 0 otherwise.
- viol_count, output, 8: saturating count of RUN->KILL transitions.

Behaviour:
- Region match i: base_i <= data_addr <= base_i+size_i-1. Compute in AW+1 bits so there is no wrap. A size of 0 never matches.
- pc_trusted: TRUST_BASE <= pc <= TRUST_BASE+TRUST_SIZE-2, in AW+1 bits.
- prev_pc register: reset value RESET_HANDLER. Loads pc when pc_en=1. prev_trusted is derived from prev_pc.
- Violation terms, evaluated combinationally:
  - V_READ: !pc_trusted && r_en && match_i && !perm_r_i.
  - V_WRITE: !pc_trusted && w_en && match_i && !perm_w_i.
  - V_ENTRY: pc_en && !prev_trusted && pc_trusted && pc != TRUST_BASE.
  - V_EXIT: pc_en && prev_trusted && !pc_trusted && prev_pc != TRUST_BASE+TRUST_SIZE-2.
  - Accesses by trusted code are always permitted.
- viol = OR of all terms.
- Cause priority: ENTRY > EXIT > WRITE > READ. Region = lowest index i that violates for the selected cause.
- State machine has 2 states, RUN and KILL; reset value is RUN.
  - RUN -> KILL when viol. Also load hold_cnt=MIN_KILL-1 and assert viol_valid next cycle.
  - KILL: hold_cnt decrements to 0 and stops there.
  - KILL -> RUN when hold_cnt==0 && pc==RESET_HANDLER && !viol.
  - In all other cases the state holds. A violation in KILL does not restart hold_cnt and is not counted.
- kill is registered and equals state. It rises the cycle after the violating cycle, and falls the cycle after the release condition.
- Sticky cause: viol_cause/viol_region load on RUN->KILL only if viol_cause==0. cause_clr zeroes them. If cause_clr and a capture happen in the same cycle, the capture wins.
- viol_count increments on RUN->KILL and saturates at 255.
- reset, including mid-KILL, forces: RUN, kill=0, viol_valid=0, cause=0, region=0, count=0, hold_cnt=0, prev_pc=RESET_HANDLER.

Optional Feature:
- XSTACK_DMA_CHECK_EN defined:
  - Adds ports dma_addr (input, AW) and dma_en (input, 1).
  - dma_en with dma_addr in any region is a violation: cause 5, lowest matching region index. Priority is below READ.
  - DMA is never trusted and ignores REGION_PERM.
- Undefined: the ports are absent and cause 5 is never produced.

Test Plan:
- pc=0xE000, w_en=1, data_addr=0x0500 -> next cycle kill=1, viol_valid=1, cause=3, region=0, count=1.
- pc=0xE000, r_en=1, data_addr=0x8004 (region1, read allowed) -> kill stays 0. Same access with w_en=1 -> kill=1, cause=3, region=1.
- prev_pc=0xE000, pc_en=1, pc=0xA010 -> cause=1. Repeat with pc=0xA000 -> no kill. Jump from prev_pc=0xA100 to pc=0x5000 -> cause=2. From prev_pc=0xDFFE -> no kill.
- Enter KILL, then drive pc=0xFFFE on the 2nd KILL cycle -> kill stays high until the 4th cycle (MIN_KILL=4), then low one cycle later. cause stays sticky until cause_clr.
- Violation plus cause_clr in the same cycle with cause=0 -> cause captured. 300 separate kill events -> viol_count=255.
- Assert reset while in KILL -> next cycle kill=0, count=0, cause=0. The DMA variant: dma_en=1, dma_addr=0xFF00 -> cause=5, region=2.
